// File: rtl/reg_writeback_demux_pkg.sv
// reg_writeback_demux_pkg: shared state enum, select encodings and default bus width
package reg_writeback_demux_pkg;
  localparam int WB_WIDTH = 3;
  typedef enum logic {IDLE, COMMIT} state_e;
  typedef enum logic [1:0] {SEL_R0 = 2'b00, SEL_R1 = 2'b01, SEL_R2 = 2'b10, SEL_R3 = 2'b11} sel_e;
endpackage

// File: rtl/reg_writeback_demux_dec2to4.sv
// dec2to4: 2-to-4 one-hot load-enable decoder with enable and all-ones broadcast
module dec2to4 (
  input  logic       en_i,
  input  logic       all_i,
  input  logic [1:0] sel_i,
  output logic [3:0] ld_o
);
  // one-hot on sel, all ones when broadcasting, nothing when disabled
  always_comb ld_o = !en_i ? 4'b0000 : all_i ? 4'b1111 : 4'b0001 << sel_i;
endmodule

// File: rtl/reg_writeback_demux.sv
// reg_writeback_demux: commits one staged bus write into r0..r3; WB_BROADCAST_EN makes sel=11 write all four
module reg_writeback_demux
  import reg_writeback_demux_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_valid_i,
  input  logic [1:0]       wr_sel_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  output logic             wr_done_o,
  input  logic             err_clr_i,
  output logic             err_o,
  output logic [WIDTH-1:0] r0_o,
  output logic [WIDTH-1:0] r1_o,
  output logic [WIDTH-1:0] r2_o,
  output logic [WIDTH-1:0] r3_o
);
  state_e           state_q;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] data_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] r_q [4];
  logic [3:0]       ld;
  logic             commit, to_r3, bcast, illegal;
  assign commit = state_q == COMMIT;
  assign to_r3  = sel_q == SEL_R3;
`ifdef WB_BROADCAST_EN
  assign bcast   = commit && to_r3;
  assign illegal = 1'b0;
`else
  assign bcast   = 1'b0;
  assign illegal = commit && to_r3;
`endif
  dec2to4 u_dec (
    .en_i  (commit && !illegal),
    .all_i (bcast),
    .sel_i (sel_q),
    .ld_o  (ld)
  );
  // handshake sequencer: capture in IDLE, commit and pulse done on the following edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= commit;
      if (commit) begin
        state_q <= IDLE;
      end else if (wr_valid_i) begin
        state_q <= COMMIT;
        sel_q   <= wr_sel_i;
        data_q  <= wr_data_i;
      end
    end
  end
  // register file: only decoded targets load, and only on the commit edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) if (ld[i]) r_q[i] <= data_q;
    end
  end
  // sticky error: an illegal commit beats a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= illegal ? 1'b1 : err_clr_i ? 1'b0 : err_q;
  end
  assign wr_ready_o = state_q == IDLE;
  assign wr_done_o  = done_q;
  assign err_o      = err_q;
  assign r0_o       = r_q[0];
  assign r1_o       = r_q[1];
  assign r2_o       = r_q[2];
  assign r3_o       = r_q[3];
endmodule

// File: tb/tb_reg_writeback_demux.sv
// tb_reg_writeback_demux: scoreboard bench; expected register/err snapshots queued at handshake, checked on wr_done
module tb_reg_writeback_demux;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_sel = 2'b00;
  logic [2:0] wr_data = 3'b000;
  logic       err_clr = 1'b0;
  logic       wr_ready, wr_done, err;
  logic [2:0] r0, r1, r2, r3;
  int total = 0;
  int bad = 0;
  int pushes = 0;
  int dones = 0;
  logic [12:0] sb_q [$];
  reg_writeback_demux dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_valid_i (wr_valid),
    .wr_sel_i   (wr_sel),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .wr_done_o  (wr_done),
    .err_clr_i  (err_clr),
    .err_o      (err),
    .r0_o       (r0),
    .r1_o       (r1),
    .r2_o       (r2),
    .r3_o       (r3)
  );
  always #5 clk = ~clk;
  function automatic logic [12:0] snap(input logic [2:0] a, b, c, d, input logic e);
    return {e, d, c, b, a};
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: every wr_done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && wr_done) begin
      dones++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got pulse expected none");
      end else begin
        chk("commit_state", {3'b000, err, r3, r2, r1, r0}, {3'b000, sb_q.pop_front()});
      end
    end
  end
  // drive a request, wait for the accepting edge; returns just after it with the count of stalled edges
  task automatic issue(input logic [1:0] s, input logic [2:0] d, input logic [12:0] exp,
                       input bit push, output int waits);
    wr_valid = 1'b1;
    wr_sel = s;
    wr_data = d;
    waits = 0;
    while (!wr_ready && waits < 10) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!wr_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got ready=0 expected 1");
    end
    @(posedge clk); #1;
    if (push) begin
      sb_q.push_back(exp);
      pushes++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    int w;
    #2;
    chk("rst_ready", 16'(wr_ready), 16'd1);
    chk("rst_done", 16'(wr_done), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_regs", {4'h0, r3, r2, r1, r0}, 16'h0000);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    // single write to r2
    issue(2'b10, 3'b101, snap(3'd0, 3'd0, 3'd5, 3'd0, 1'b0), 1, w);
    wr_valid = 1'b0;
    chk("t1_ready_low", 16'(wr_ready), 16'd0);
    chk("t1_r2_not_yet", 16'(r2), 16'd0);
    @(posedge clk); #1;
    chk("t1_ready_back", 16'(wr_ready), 16'd1);
    chk("t1_done", 16'(wr_done), 16'd1);
    chk("t1_r2", 16'(r2), 16'd5);
    @(posedge clk); #1;
    chk("t1_done_once", 16'(wr_done), 16'd0);
    // back-to-back with valid held high
    issue(2'b00, 3'b001, snap(3'd1, 3'd0, 3'd5, 3'd0, 1'b0), 1, w);
    issue(2'b01, 3'b010, snap(3'd1, 3'd2, 3'd5, 3'd0, 1'b0), 1, w);
    chk("b2b_gap1", 16'(w), 16'd1);
    issue(2'b10, 3'b011, snap(3'd1, 3'd2, 3'd3, 3'd0, 1'b0), 1, w);
    chk("b2b_gap2", 16'(w), 16'd1);
`ifdef WB_BROADCAST_EN
    issue(2'b11, 3'b100, snap(3'd4, 3'd4, 3'd4, 3'd4, 1'b0), 1, w);
`else
    issue(2'b11, 3'b100, snap(3'd1, 3'd2, 3'd3, 3'd0, 1'b1), 1, w);
`endif
    chk("b2b_gap3", 16'(w), 16'd1);
    wr_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_no_recapture", 16'(wr_ready), 16'd1);
    // clear and new illegal commit on the same edge: set wins
`ifdef WB_BROADCAST_EN
    issue(2'b11, 3'b110, snap(3'd6, 3'd6, 3'd6, 3'd6, 1'b0), 1, w);
`else
    issue(2'b11, 3'b110, snap(3'd1, 3'd2, 3'd3, 3'd0, 1'b1), 1, w);
`endif
    wr_valid = 1'b0;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_cleared", 16'(err), 16'd0);
    // data changed during COMMIT: staged value wins
`ifdef WB_BROADCAST_EN
    issue(2'b00, 3'b011, snap(3'd3, 3'd6, 3'd6, 3'd6, 1'b0), 1, w);
`else
    issue(2'b00, 3'b011, snap(3'd3, 3'd2, 3'd3, 3'd0, 1'b0), 1, w);
`endif
    wr_valid = 1'b0;
    wr_data = 3'b100;
    @(posedge clk); #1;
    chk("hold_r0", 16'(r0), 16'd3);
    @(posedge clk); #1;
    // reset during COMMIT discards the pending write
    issue(2'b01, 3'b111, 13'd0, 0, w);
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_mid_regs", {4'h0, r3, r2, r1, r0}, 16'h0000);
    chk("rst_mid_ready", 16'(wr_ready), 16'd1);
    chk("rst_mid_err", 16'(err), 16'd0);
    w = dones;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_no_done", 16'(dones), 16'(w));
    chk("rst_mid_r1", 16'(r1), 16'd0);
    chk("rst_after_ready", 16'(wr_ready), 16'd1);
    issue(2'b01, 3'b110, snap(3'd0, 3'd6, 3'd0, 3'd0, 1'b0), 1, w);
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 16'(sb_q.size()), 16'd0);
    chk("done_count", 16'(dones), 16'(pushes));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
